// File: rtl/axis_cnt_pkg.sv
// Shared definitions for the counting-pattern stream checker: pattern field
// widths, expected-data helper, backpressure LFSR constants and FSM states.
package axis_cnt_pkg;

    localparam int unsigned FRAME_W   = 16;
    localparam int unsigned BEAT_W    = 16;
    localparam int unsigned PATTERN_W = FRAME_W + BEAT_W;

    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [0:0] {
        StCheck,
        StSync
    } state_e;

    // Beat payload produced by the counter source.
    function automatic logic [PATTERN_W-1:0] exp_pattern(
        input logic [FRAME_W-1:0] frame,
        input logic [BEAT_W-1:0]  beat
    );
        return {frame, beat};
    endfunction

    // One step of the Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/axis_bp_lfsr.sv
// Seeded 16-bit Galois LFSR with step enable; drives pseudo-random
// ready/valid throttling on either side of a stream.
module axis_bp_lfsr
    import axis_cnt_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Advance one step per enabled cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // State register; seed must be nonzero or the sequence locks up.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/axis_counter_sink.sv
// AXI-Stream sink that checks the counting frame pattern, tracks frame and
// error statistics and optionally throttles TREADY from an LFSR.
module axis_counter_sink
    import axis_cnt_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned KEEP_W      = DATA_W / 8,
    parameter int unsigned USER_W      = 1,
    parameter int unsigned FRAME_BEATS = 8,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              bp_en,
    output logic [31:0]       frame_cnt,
    output logic [31:0]       good_frame_cnt,
    output logic [15:0]       err_cnt,
    output logic              err_sticky,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp,
    output logic              frame_done,
    output logic              synced
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

    // Backpressure source runs freely from reset, independent of traffic.
    logic [15:0] lfsr;
    logic        unused_lfsr;

    axis_bp_lfsr #(
        .SEED (LFSR_SEED)
    ) u_bp_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:1];

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   exp_beat_q, exp_beat_d;
    logic [FRAME_W-1:0]  exp_frame_q, exp_frame_d;
    logic                frame_bad_q, frame_bad_d;
    logic [31:0]         frame_cnt_q, frame_cnt_d;
    logic [31:0]         good_cnt_q, good_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                err_sticky_q, err_sticky_d;
    logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;
    logic [DATA_W-1:0]   first_err_exp_q, first_err_exp_d;
    logic                frame_done_q, frame_done_d;
    logic                tready_q, tready_d;

    logic                accept;
    logic [DATA_W-1:0]   exp_data;
    logic                exp_last;
    logic                beat_err;
    logic [FRAME_W-1:0]  resync_frame;

    assign accept   = s_axis_tvalid & tready_q;
    // Size cast truncates narrow buses and zero-extends wide ones.
    assign exp_data = DATA_W'(exp_pattern(exp_frame_q, exp_beat_q));
    assign exp_last = (exp_beat_q == LAST_BEAT);

    // Any failing field makes the beat erroneous; it still counts once.
    assign beat_err = (s_axis_tdata != exp_data)
                    | (s_axis_tlast != exp_last)
                    | (s_axis_tkeep != {KEEP_W{1'b1}})
                    | (s_axis_tuser != {USER_W{1'b0}});

    // Frame number to resume from after resync: taken from the stream when
    // the frame field is carried, otherwise just advance our own count.
    if (DATA_W >= 32) begin : g_frame_from_data
        assign resync_frame = s_axis_tdata[31:16] + 1'b1;
    end else begin : g_frame_from_count
        assign resync_frame = exp_frame_q + 1'b1;
    end

    // Next-state for checker FSM, counters and capture registers.
    always_comb begin
        state_d          = state_q;
        exp_beat_d       = exp_beat_q;
        exp_frame_d      = exp_frame_q;
        frame_bad_d      = frame_bad_q;
        frame_cnt_d      = frame_cnt_q;
        good_cnt_d       = good_cnt_q;
        err_cnt_d        = err_cnt_q;
        err_sticky_d     = err_sticky_q;
        first_err_data_d = first_err_data_q;
        first_err_exp_d  = first_err_exp_q;
        frame_done_d     = 1'b0;
        tready_d         = ~bp_en | lfsr[0];

        if (accept) begin
            // Frame accounting is independent of checker state.
            if (s_axis_tlast) begin
                frame_cnt_d  = frame_cnt_q + 32'd1;
                frame_done_d = 1'b1;
            end

            unique case (state_q)
                StCheck: begin
                    if (beat_err) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (!err_sticky_q) begin
                            err_sticky_d     = 1'b1;
                            first_err_data_d = s_axis_tdata;
                            first_err_exp_d  = exp_data;
                        end
                        frame_bad_d = 1'b1;
                        state_d     = StSync;
                    end else if (exp_last) begin
                        // Clean beat that also matched the expected TLAST.
                        if (!frame_bad_q) begin
                            good_cnt_d = good_cnt_q + 32'd1;
                        end
                        frame_bad_d = 1'b0;
                        exp_beat_d  = '0;
                        exp_frame_d = exp_frame_q + 1'b1;
                    end else begin
                        exp_beat_d = exp_beat_q + 1'b1;
                    end
                end
                StSync: begin
                    // Beats are ignored until a frame boundary is seen.
                    if (s_axis_tlast) begin
                        state_d     = StCheck;
                        frame_bad_d = 1'b0;
                        exp_beat_d  = '0;
                        exp_frame_d = resync_frame;
                    end
                end
                default: state_d = StCheck;
            endcase
        end
    end

    // All state and status outputs; synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q          <= StCheck;
            exp_beat_q       <= '0;
            exp_frame_q      <= '0;
            frame_bad_q      <= 1'b0;
            frame_cnt_q      <= '0;
            good_cnt_q       <= '0;
            err_cnt_q        <= '0;
            err_sticky_q     <= 1'b0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            frame_done_q     <= 1'b0;
            tready_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            exp_beat_q       <= exp_beat_d;
            exp_frame_q      <= exp_frame_d;
            frame_bad_q      <= frame_bad_d;
            frame_cnt_q      <= frame_cnt_d;
            good_cnt_q       <= good_cnt_d;
            err_cnt_q        <= err_cnt_d;
            err_sticky_q     <= err_sticky_d;
            first_err_data_q <= first_err_data_d;
            first_err_exp_q  <= first_err_exp_d;
            frame_done_q     <= frame_done_d;
            tready_q         <= tready_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign frame_cnt      = frame_cnt_q;
    assign good_frame_cnt = good_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign err_sticky     = err_sticky_q;
    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;
    assign frame_done     = frame_done_q;
    assign synced         = (state_q == StCheck);

endmodule

// File: tb/tb_axis_counter_sink.sv
// Self-checking bench for axis_counter_sink: drives counting frames with
// injected faults and scoreboards the per-frame counter snapshots.
module tb_axis_counter_sink;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = 4;

    logic              aclk;
    logic              aresetn;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic              s_axis_tlast;
    logic [0:0]        s_axis_tuser;
    logic              bp_en;
    logic [31:0]       frame_cnt;
    logic [31:0]       good_frame_cnt;
    logic [15:0]       err_cnt;
    logic              err_sticky;
    logic [DATA_W-1:0] first_err_data;
    logic [DATA_W-1:0] first_err_exp;
    logic              frame_done;
    logic              synced;

    axis_counter_sink #(
        .DATA_W      (DATA_W),
        .KEEP_W      (KEEP_W),
        .USER_W      (1),
        .FRAME_BEATS (8),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .bp_en          (bp_en),
        .frame_cnt      (frame_cnt),
        .good_frame_cnt (good_frame_cnt),
        .err_cnt        (err_cnt),
        .err_sticky     (err_sticky),
        .first_err_data (first_err_data),
        .first_err_exp  (first_err_exp),
        .frame_done     (frame_done),
        .synced         (synced)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] frames;
        logic [31:0] good;
        logic [15:0] errs;
    } snap_t;

    snap_t       sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned m_frames = 0;
    int unsigned m_good   = 0;
    int unsigned m_err    = 0;
    bit          meas_en  = 1'b0;
    int unsigned meas_total = 0;
    int unsigned meas_low   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every frame_done pulse pops one expected counter snapshot.
    always @(negedge aclk) begin
        if (aresetn && frame_done) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_frame_done", 64'(sb_q.size()), 64'd1);
            end else begin
                snap_t s;
                s = sb_q.pop_front();
                check_eq("sb_frame_cnt", 64'(frame_cnt), 64'(s.frames));
                check_eq("sb_good_cnt", 64'(good_frame_cnt), 64'(s.good));
                check_eq("sb_err_cnt", 64'(err_cnt), 64'(s.errs));
            end
        end
    end

    // Ready duty measurement during the throttled run.
    always @(negedge aclk) begin
        if (meas_en) begin
            meas_total++;
            if (!s_axis_tready) meas_low++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_beat(input logic [31:0] data, input logic last,
                             input logic [3:0] keep, input logic user);
        int  n;
        logic rdy;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        s_axis_tkeep  = keep;
        s_axis_tuser  = user;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 1000) begin
            rdy = s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!rdy) check_eq("accept_timeout", 64'(rdy), 64'd1);
    endtask

    // kind: 0 clean, 1 data replaced, 2 bad TKEEP, 3 TLAST dropped.
    // counted: the fault hits a checked beat; good: frame should count good.
    task automatic send_frame(input int fid, input int bad_beat, input logic [31:0] bad_data,
                              input int kind, input bit counted, input bit good);
        for (int b = 0; b < 8; b++) begin
            logic [31:0] d;
            logic        l;
            logic [3:0]  k;
            bit          hit;
            d   = {fid[15:0], b[15:0]};
            l   = (b == 7);
            k   = 4'hF;
            hit = (kind != 0) && (b == bad_beat);
            if (hit) begin
                if (kind == 1) d = bad_data;
                if (kind == 2) k = 4'b0111;
                if (kind == 3) l = 1'b0;
                if (counted) m_err++;
            end
            if (l) begin
                m_frames++;
                if (good) m_good++;
                sb_q.push_back('{frames: 32'(m_frames), good: 32'(m_good), errs: 16'(m_err)});
            end
            send_beat(d, l, k, 1'b0);
            if (hit && counted) begin
                check_eq("synced_after_err", 64'(synced), 64'd0);
                check_eq("sticky_after_err", 64'(err_sticky), 64'd1);
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle_and_drain(input string tag);
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b0;
        @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        sb_q.delete();
        m_frames = 0;
        m_good   = 0;
        m_err    = 0;
    endtask

    initial begin
        aresetn       = 1'b0;
        bp_en         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        repeat (3) @(posedge aclk);
        #1;

        // Reset values.
        check_eq("rst_tready", 64'(s_axis_tready), 64'd0);
        check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("rst_good_cnt", 64'(good_frame_cnt), 64'd0);
        check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("rst_sticky", 64'(err_sticky), 64'd0);
        check_eq("rst_first_data", 64'(first_err_data), 64'd0);
        check_eq("rst_first_exp", 64'(first_err_exp), 64'd0);
        check_eq("rst_frame_done", 64'(frame_done), 64'd0);
        check_eq("rst_synced", 64'(synced), 64'd1);

        aresetn = 1'b1;
        check_eq("tready_at_release", 64'(s_axis_tready), 64'd0);
        @(posedge aclk);
        #1;
        check_eq("tready_after_release", 64'(s_axis_tready), 64'd1);

        // Four clean frames at full rate.
        for (int f = 0; f < 4; f++) send_frame(f, 0, 32'h0, 0, 1'b0, 1'b1);
        idle_and_drain("clean");
        check_eq("clean_frame_cnt", 64'(frame_cnt), 64'd4);
        check_eq("clean_good_cnt", 64'(good_frame_cnt), 64'd4);
        check_eq("clean_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("clean_synced", 64'(synced), 64'd1);

        // Throttled ready, 100 frames.
        do_reset();
        bp_en   = 1'b1;
        meas_en = 1'b1;
        for (int f = 0; f < 100; f++) send_frame(f, 0, 32'h0, 0, 1'b0, 1'b1);
        meas_en = 1'b0;
        idle_and_drain("bp");
        check_eq("bp_good_cnt", 64'(good_frame_cnt), 64'd100);
        check_eq("bp_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("bp_low_25pct", 64'(meas_low * 4 >= meas_total), 64'd1);
        bp_en = 1'b0;

        // Data corruption in frame 2 beat 3.
        do_reset();
        for (int f = 0; f < 6; f++) begin
            if (f == 2) send_frame(f, 3, 32'hDEAD0003, 1, 1'b1, 1'b0);
            else        send_frame(f, 0, 32'h0, 0, 1'b0, 1'b1);
        end
        idle_and_drain("data");
        check_eq("data_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("data_first_data", 64'(first_err_data), 64'hDEAD0003);
        check_eq("data_first_exp", 64'(first_err_exp), 64'h00020003);
        check_eq("data_good_cnt", 64'(good_frame_cnt), 64'd5);
        check_eq("data_frame_cnt", 64'(frame_cnt), 64'd6);
        check_eq("data_synced", 64'(synced), 64'd1);

        // TLAST dropped on frame 0 beat 7: frame 1 is swallowed while resyncing.
        do_reset();
        send_frame(0, 7, 32'h0, 3, 1'b1, 1'b0);
        send_frame(1, 0, 32'h0, 0, 1'b0, 1'b0);
        send_frame(2, 0, 32'h0, 0, 1'b0, 1'b1);
        send_frame(3, 0, 32'h0, 0, 1'b0, 1'b1);
        idle_and_drain("nolast");
        check_eq("nolast_frame_cnt", 64'(frame_cnt), 64'd3);
        check_eq("nolast_good_cnt", 64'(good_frame_cnt), 64'd2);
        check_eq("nolast_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("nolast_first_exp", 64'(first_err_exp), 64'h00000007);
        check_eq("nolast_synced", 64'(synced), 64'd1);

        // Partial TKEEP on frame 1 beat 2.
        do_reset();
        send_frame(0, 0, 32'h0, 0, 1'b0, 1'b1);
        send_frame(1, 2, 32'h0, 2, 1'b1, 1'b0);
        send_frame(2, 0, 32'h0, 0, 1'b0, 1'b1);
        send_frame(3, 0, 32'h0, 0, 1'b0, 1'b1);
        idle_and_drain("keep");
        check_eq("keep_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("keep_good_cnt", 64'(good_frame_cnt), 64'd3);
        check_eq("keep_first_data", 64'(first_err_data), 64'h00010002);
        check_eq("keep_first_exp", 64'(first_err_exp), 64'h00010002);

        // Reset mid-frame, then restart from frame 0.
        do_reset();
        send_frame(0, 0, 32'h0, 0, 1'b0, 1'b1);
        for (int b = 0; b < 4; b++) send_beat({16'd1, 16'(b)}, 1'b0, 4'hF, 1'b0);
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b0;
        @(posedge aclk);
        #1;
        check_eq("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("midrst_good_cnt", 64'(good_frame_cnt), 64'd0);
        check_eq("midrst_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("midrst_synced", 64'(synced), 64'd1);
        check_eq("midrst_tready", 64'(s_axis_tready), 64'd0);
        aresetn  = 1'b1;
        sb_q.delete();
        m_frames = 0;
        m_good   = 0;
        m_err    = 0;
        for (int f = 0; f < 4; f++) send_frame(f, 0, 32'h0, 0, 1'b0, 1'b1);
        idle_and_drain("restart");
        check_eq("restart_frame_cnt", 64'(frame_cnt), 64'd4);
        check_eq("restart_good_cnt", 64'(good_frame_cnt), 64'd4);
        check_eq("restart_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("restart_sticky", 64'(err_sticky), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
